// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants for the writeback arbiter
package wb_pkg;

    localparam int WB_NREQ    = 3;
    localparam int WB_AW      = 5;
    localparam int WB_DW      = 32;
    localparam int WB_PTR_W   = 2;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    localparam logic [WB_AW-1:0] ZERO_REG = 5'd0;

    typedef logic [WB_PTR_W-1:0] wb_ptr_t;

endpackage

// File: rtl/decoder.sv
// rtl/decoder.sv - 5-to-32 one-hot register decoder
module decoder (
    input  logic [4:0]  a,
    output logic [31:0] y
);

    assign y = 32'd1 << a;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin register-file write port arbiter
// Optional conflict counter enabled by WB_CONFLICT_CNT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int AW   = WB_AW,
    parameter int DW   = WB_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                wb_stall,
`ifdef WB_CONFLICT_CNT_EN
    output logic [15:0]         conflict_cnt,
`endif
    output logic                we,
    output logic [AW-1:0]       wa,
    output logic [DW-1:0]       wd,
    output logic [31:0]         we_onehot
);

    wb_ptr_t           r_ptr;
    logic              r_we;
    logic [AW-1:0]     r_wa;
    logic [DW-1:0]     r_wd;

    logic [NREQ-1:0]   w_grant;
    wb_ptr_t           w_gidx;
    wb_ptr_t           w_next_ptr;
    logic              w_xfer;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_data;
    logic [31:0]       w_dec;

    // Rotating priority: scan from ptr upward, first valid requester wins.
    always_comb begin
        logic found;
        int   idx;
        w_grant = '0;
        w_gidx  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found          = 1'b1;
                w_grant[idx]   = 1'b1;
                w_gidx         = wb_ptr_t'(idx);
            end
        end
        if (wb_stall || !rst) begin
            w_grant = '0;
        end
    end

    assign req_ready  = w_grant;
    assign w_xfer     = |w_grant;
    assign w_next_ptr = (w_gidx == wb_ptr_t'(NREQ-1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
                w_sel_data = w_sel_data | req_data[i*DW +: DW];
            end
        end
    end

    // Writes to $zero are accepted but never strobed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_we  <= 1'b0;
            r_wa  <= '0;
            r_wd  <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_next_ptr;
            r_we  <= (w_sel_addr != ZERO_REG);
            r_wa  <= w_sel_addr;
            r_wd  <= w_sel_data;
        end else begin
            r_we  <= 1'b0;
        end
    end

    decoder u_decoder (
        .a (r_wa),
        .y (w_dec)
    );

    assign we        = r_we;
    assign wa        = r_wa;
    assign wd        = r_wd;
    assign we_onehot = r_we ? w_dec : 32'd0;

`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;
    logic        w_multi;

    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
            n = n + int'(req_valid[i]);
        end
        w_multi = (n >= 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
        end else if (w_multi && !wb_stall && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    // Conflict counter not built.
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_stall;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] we_onehot;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    int total = 0;
    int bad   = 0;

    wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_stall     (wb_stall),
`ifdef WB_CONFLICT_CNT_EN
        .conflict_cnt (conflict_cnt),
`endif
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .we_onehot    (we_onehot)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset;
        rst = 1'b0; wb_stall = 1'b0; req_valid = 3'b111;
        req_addr = '0; req_data = '0;
        set_req(0, 5'd1, 32'hA0A0_A0A0);
        set_req(1, 5'd2, 32'hB1B1_B1B1);
        set_req(2, 5'd3, 32'hC2C2_C2C2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
        total++; if (we_onehot !== 32'd0) begin bad++; $display("FAIL reset_onehot got=%h exp=0", we_onehot); end
        total++; if (wa !== 5'd0 || wd !== 32'd0) begin bad++; $display("FAIL reset_wa_wd got=%0d/%h exp=0/0", wa, wd); end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL first_grant got=%b exp=001", req_ready); end
        @(posedge clk); #1 req_valid = 3'b000;
        total++; if (we !== 1'b1 || wa !== 5'd1 || wd !== 32'hA0A0_A0A0) begin bad++; $display("FAIL first_write got=%b/%0d/%h exp=1/1/a0a0a0a0", we, wa, wd); end
    endtask

    task automatic test_single;
        set_req(1, 5'd8, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        @(negedge clk);
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b exp=010", req_ready); end
        @(posedge clk); #1 req_valid = 3'b000;
        total++; if (we !== 1'b1 || wa !== 5'd8 || wd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/8/deadbeef", we, wa, wd); end
        total++; if (we_onehot !== 32'h0000_0100) begin bad++; $display("FAIL single_onehot got=%h exp=00000100", we_onehot); end
        @(posedge clk); #1;
        total++; if (we !== 1'b0 || we_onehot !== 32'd0 || wa !== 5'd8) begin bad++; $display("FAIL single_pulse got=%b/%h/%0d exp=0/0/8", we, we_onehot, wa); end
    endtask

    task automatic test_async_reset;
        set_req(2, 5'd3, 32'hC3C3_C3C3);
        req_valid = 3'b100;
        @(posedge clk); #1;
        total++; if (we !== 1'b1 || wa !== 5'd3) begin bad++; $display("FAIL pre_reset_write got=%b/%0d exp=1/3", we, wa); end
        rst = 1'b0; #1;
        total++; if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || we_onehot !== 32'd0 || req_ready !== 3'b000) begin
            bad++; $display("FAIL async_reset got=%b/%0d/%h/%h/%b exp=0/0/0/0/000", we, wa, wd, we_onehot, req_ready);
        end
        req_valid = 3'b000;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < 3; i++) set_req(i, 5'(5 + i), 32'h1000_0000 + i);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (req_ready !== (3'b001 << (c % 3))) begin bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, 3'b001 << (c % 3)); end
            @(posedge clk); #1;
            total++; if (we !== 1'b1 || wa !== 5'(5 + c % 3) || wd !== 32'h1000_0000 + (c % 3) || we_onehot !== (32'd1 << (5 + c % 3))) begin
                bad++; $display("FAIL rr_write c=%0d got=%b/%0d/%h/%h exp=1/%0d", c, we, wa, wd, we_onehot, 5 + c % 3);
            end
        end
        req_valid = 3'b000;
        @(posedge clk); #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b exp=0", we); end
    endtask

    task automatic test_zero_write;
        set_req(2, 5'd0, 32'h0000_0001);
        req_valid = 3'b100;
        @(negedge clk);
        total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL zero_ready got=%b exp=100", req_ready); end
        @(posedge clk); #1;
        total++; if (we !== 1'b0 || we_onehot !== 32'd0 || wa !== 5'd0 || wd !== 32'd1) begin
            bad++; $display("FAIL zero_write got=%b/%h/%0d/%h exp=0/0/0/1", we, we_onehot, wa, wd);
        end
        set_req(2, 5'd7, 32'h1000_0002);
        req_valid = 3'b111;
        @(negedge clk);
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL zero_ptr got=%b exp=001", req_ready); end
    endtask

    task automatic test_stall;
        @(posedge clk); #1 wb_stall = 1'b1;
        total++; if (we !== 1'b1 || wa !== 5'd5) begin bad++; $display("FAIL stall_inflight got=%b/%0d exp=1/5", we, wa); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=000", c, req_ready); end
            @(posedge clk); #1;
            total++; if (we !== 1'b0) begin bad++; $display("FAIL stall_we c=%0d got=%b exp=0", c, we); end
        end
        wb_stall = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL stall_resume got=%b exp=010", req_ready); end
        @(posedge clk); #1 req_valid = 3'b000;
        total++; if (we !== 1'b1 || wa !== 5'd6) begin bad++; $display("FAIL stall_resume_write got=%b/%0d exp=1/6", we, wa); end
    endtask

    task automatic test_back_to_back;
        set_req(0, 5'd9, 32'h0000_AAAA);
        set_req(1, 5'd9, 32'h0000_BBBB);
        req_valid = 3'b011;
        @(negedge clk);
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL b2b_ready0 got=%b exp=001", req_ready); end
        @(posedge clk); #1 req_valid = 3'b010;
        total++; if (we !== 1'b1 || wa !== 5'd9 || wd !== 32'h0000_AAAA) begin bad++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/9/aaaa", we, wa, wd); end
        @(negedge clk);
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL b2b_ready1 got=%b exp=010", req_ready); end
        @(posedge clk); #1 req_valid = 3'b000;
        total++; if (we !== 1'b1 || wa !== 5'd9 || wd !== 32'h0000_BBBB) begin bad++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/9/bbbb", we, wa, wd); end
        @(posedge clk); #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", we); end
    endtask

`ifdef WB_CONFLICT_CNT_EN
    task automatic test_counter;
        rst = 1'b0; #1;
        total++; if (conflict_cnt !== 16'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", conflict_cnt); end
        @(posedge clk); #1 rst = 1'b1;
        req_valid = 3'b011;
        repeat (5) @(posedge clk);
        #1 wb_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (conflict_cnt !== 16'd5) begin bad++; $display("FAIL cnt_value got=%0d exp=5", conflict_cnt); end
        wb_stall = 1'b0; req_valid = 3'b000;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_async_reset();
        test_round_robin();
        test_zero_write();
        test_stall();
        test_back_to_back();
`ifdef WB_CONFLICT_CNT_EN
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter sharing the single register-file write port of the MIPS datapath among NREQ writeback requesters (ALU, load unit, mult/div unit). Grants at most one request per cycle, registers the winning address/data, and drives the per-register one-hot write enables through the existing 5-to-32 `decoder`. Sits between the writeback sources and the register file.

## Interface
- NREQ, 3: number of requesters (2..4); index 0 = ALU, 1 = load, 2 = mult/div
- AW, 5: register address width (fixed by the 32-entry register file)
- DW, 32: write data width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request i has a pending write
- req_addr  in  NREQ×AW  destination register per requester
- req_data  in  NREQ×DW  write data per requester
- req_ready  out  NREQ  one-hot grant; transfer i occurs when req_valid[i] & req_ready[i]
- wb_stall  in  1  pipeline freeze; blocks new grants
- we  out  1  register-file write strobe
- wa  out  AW  registered write address
- wd  out  DW  registered write data
- we_onehot  out  32  decoded per-register enable, equals decoder(wa) when we=1, else 0
- conflict_cnt  out  16  only with WB_CONFLICT_CNT_EN; see Configuration

## Operation
- Round-robin pointer `ptr` (0..NREQ-1): highest priority goes to ptr, then ptr+1, … wrapping modulo NREQ.
- Grant: if wb_stall=0, req_ready[i]=1 for exactly the first valid requester in priority order; all other ready bits 0. If wb_stall=1 or no valid request, req_ready=0.
- req_ready is combinational from req_valid, ptr and wb_stall; it must not depend on req_addr/req_data.
- On a transfer from requester g: next ptr = (g+1) mod NREQ; wa<=req_addr[g], wd<=req_data[g].
- we<=1 on the cycle after a transfer, unless req_addr[g]==0 (write to $zero): the request is still accepted and ptr still advances, but we<=0.
- No transfer in a cycle → we<=0 next cycle; wa/wd hold their last values.
- we is a single-cycle pulse per accepted write; never held across cycles for one request.
- Same destination from two requesters in consecutive grants → two writes in grant order; the later wins in the register file.
- Requesters hold valid/addr/data stable until granted; arbiter does not check this.

## Timing
- Reset (rst=0, asynchronous): ptr=0, we=0, wa=0, wd=0, we_onehot=0, conflict_cnt=0; req_ready=0 while rst=0. A write captured before reset is discarded (never strobed).
- Latency: request granted in cycle N → we/wa/wd valid in cycle N+1; we_onehot valid in N+1 (combinational from wa and we).
- Throughput: one write per cycle sustained with continuous requests.
- wb_stall asserted in cycle N: no grant in N; a write captured in N-1 still strobes in N.
- Fairness: with all NREQ requesters continuously valid, each is granted once every NREQ cycles.

## Configuration
- WB_CONFLICT_CNT_EN defined: conflict_cnt port exists; 16-bit saturating counter increments by 1 each cycle with wb_stall=0 where two or more req_valid bits are high; holds at 16'hFFFF; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `wb_pkg`: NREQ default, requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2), AW, DW, ZERO_REG=5'd0.
- Sub-module: the existing `decoder` (a[4:0] → y[31:0]) instantiated once on wa; output ANDed with we to form we_onehot.
- Priority selection in a function or always_comb block; no other sub-modules.

## Test plan
- Reset: hold rst=0 with req_valid=3'b111 → req_ready=0, we=0, we_onehot=0; release → first grant to req 0.
- Single request: req 1 valid, addr=5'd8, data=32'hDEADBEEF → ready[1]=1 same cycle; next cycle we=1, wa=8, wd=32'hDEADBEEF, we_onehot=32'h0000_0100.
- Round-robin: all three valid for 6 cycles → grant order 0,1,2,0,1,2; each we pulse carries matching addr/data.
- $zero write: req 2 valid, addr=0, data=32'h1 → ready[2]=1, next cycle we=0, we_onehot=0, ptr advanced to 0.
- Stall: all valid, wb_stall=1 for 3 cycles → req_ready=0 throughout; in-flight write strobes once; after release grant resumes at current ptr.
- Counter (WB_CONFLICT_CNT_EN): two valid for 5 unstalled cycles plus 2 stalled → conflict_cnt=5.
